// File: rtl/arb_pkg.sv
// Shared constants, FSM states and helpers for rr_arbiter8.
// Imported by the interface, the priority encoder and the top.
package arb_pkg;

  localparam int N = 8;
  localparam int IDW = 3;
  localparam int MAX_HOLD = 16;
  localparam int HCW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RELEASE
  } state_t;

  function automatic logic [N-1:0] onehot(
    input logic [IDW-1:0] i
  );
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_arbiter8_if.sv
// Requester-side bundle for rr_arbiter8: en/req/done in,
// gnt/gnt_id/gnt_valid/timeout out.
interface rr_arbiter8_if;
  import arb_pkg::*;

  logic           en;
  logic [N-1:0]   req;
  logic           done;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           gnt_valid;
  logic           timeout;

  modport master (
    output en, req, done,
    input  gnt, gnt_id, gnt_valid, timeout
  );

  modport slave (
    input  en, req, done,
    output gnt, gnt_id, gnt_valid, timeout
  );

endinterface

// File: rtl/rr_prio_enc.sv
// Rotating priority encoder: first set req bit scanning
// ptr, ptr+1, ... (mod N). Ports: req, ptr in; any, idx out.
import arb_pkg::*;

module rr_prio_enc (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           any,
  output logic [IDW-1:0] idx
);

  logic [IDW-1:0] j;

  // Walk from farthest to nearest so the nearest hit wins.
  always_comb begin
    any = |req;
    idx = '0;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = ptr + IDW'(k);
      if (req[j]) idx = j;
    end
  end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter, 8 requesters, hold timeout.
// Ports: clk, rst_n (async low), bus (slave modport).
import arb_pkg::*;

module rr_arbiter8 (
  input  logic         clk,
  input  logic         rst_n,
  rr_arbiter8_if.slave bus
);

  state_t         st;
  logic [IDW-1:0] ptr;
  logic [HCW-1:0] hcnt;
  logic [N-1:0]   gnt_q;
  logic [IDW-1:0] id_q;
  logic           vld_q;
  logic           to_q;

  logic           any;
  logic [IDW-1:0] idx;
  logic           own_req;
  logic           hit;
  logic           rel;

  rr_prio_enc u_enc (
    .req (bus.req),
    .ptr (ptr),
    .any (any),
    .idx (idx)
  );

  assign own_req = bus.req[id_q];
  assign hit = hcnt == HCW'(MAX_HOLD - 1);
  assign rel = bus.done | ~own_req | hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st    <= IDLE;
      ptr   <= '0;
      hcnt  <= '0;
      gnt_q <= '0;
      id_q  <= '0;
      vld_q <= 1'b0;
      to_q  <= 1'b0;
    end else begin
      to_q <= 1'b0;
      unique case (st)
        IDLE: begin
          if (bus.en && any) begin
            gnt_q <= onehot(idx);
            id_q  <= idx;
            vld_q <= 1'b1;
            hcnt  <= '0;
            st    <= BUSY;
          end
        end
        BUSY: begin
          if (rel) begin
            gnt_q <= '0;
            vld_q <= 1'b0;
            ptr   <= id_q + IDW'(1);
            // Only a pure hold expiry counts as a timeout.
            to_q  <= hit & ~bus.done & own_req;
            st    <= RELEASE;
          end else if (!hit) begin
            hcnt <= hcnt + HCW'(1);
          end
        end
        RELEASE: st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_id    = id_q;
  assign bus.gnt_valid = vld_q;
  assign bus.timeout   = to_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: directed scenarios
// plus randomized traffic against a behavioural model.
module tb_rr_arbiter8;

  localparam int HOLD = 16;

  logic clk;
  logic rst_n;

  rr_arbiter8_if bus ();

  rr_arbiter8 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: owner (-1 = none), cycles held, bubble flag.
  int m_owner;
  int m_age;
  int m_ptr;
  int m_last;
  bit m_bub;
  bit m_to;

  task automatic model_reset();
    m_owner = -1;
    m_age = 0;
    m_ptr = 0;
    m_last = 0;
    m_bub = 0;
    m_to = 0;
  endtask

  task automatic model_step(
    input bit e, input logic [7:0] r, input bit d
  );
    m_to = 0;
    if (m_owner >= 0) begin
      if (d || !r[m_owner] || m_age == HOLD - 1) begin
        m_to = !d && r[m_owner];
        m_ptr = (m_owner + 1) % 8;
        m_owner = -1;
        m_bub = 1;
      end else begin
        m_age++;
      end
    end else if (m_bub) begin
      m_bub = 0;
    end else if (e && r != 0) begin
      for (int k = 7; k >= 0; k--)
        if (r[(m_ptr + k) % 8]) m_owner = (m_ptr + k) % 8;
      m_last = m_owner;
      m_age = 0;
    end
  endtask

  task automatic chk(
    input string nm, input logic [31:0] act,
    input logic [31:0] exp
  );
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  task automatic compare();
    logic [7:0] eg;
    logic [7:0] g;
    logic [2:0] gi;
    eg = 8'h00;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    g = bus.gnt;
    gi = bus.gnt_id;
    chk("gnt", 32'(g), 32'(eg));
    chk("gnt_id", 32'(gi), 32'(m_last));
    chk("gnt_valid", 32'(bus.gnt_valid), 32'(m_owner >= 0));
    chk("timeout", 32'(bus.timeout), 32'(m_to));
    chk("invariant",
        {30'd0, $countones(g) <= 1, g[gi] == bus.gnt_valid},
        32'd3);
  endtask

  // Called at a negedge; ends at the next negedge.
  task automatic tick(
    input bit e, input logic [7:0] r, input bit d
  );
    bus.en = e;
    bus.req = r;
    bus.done = d;
    @(posedge clk);
    model_step(e, r, d);
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset();
    bus.en = 1'b0;
    bus.req = '0;
    bus.done = 1'b0;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rst_gnt", 32'(bus.gnt), 32'h0);
    chk("rst_valid", 32'(bus.gnt_valid), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    compare();
  endtask

  int held;
  int tos;
  bit e;
  logic [7:0] r;
  bit d;

  initial begin
    rst_n = 1'b0;
    bus.en = 1'b0;
    bus.req = '0;
    bus.done = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_gnt_id", 32'(bus.gnt_id), 32'h0);
    chk("rst_timeout", 32'(bus.timeout), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic grant, release, bubble, pointer advance.
    tick(1, 8'h01, 0);
    chk("g0_gnt", 32'(bus.gnt), 32'h01);
    chk("g0_valid", 32'(bus.gnt_valid), 32'h1);
    tick(1, 8'h01, 1);
    chk("rel_gnt", 32'(bus.gnt), 32'h00);
    tick(1, 8'h03, 0);
    chk("bubble", 32'(bus.gnt_valid), 32'h0);
    tick(1, 8'h03, 0);
    chk("ptr1_id", 32'(bus.gnt_id), 32'h1);
    tick(1, 8'h03, 1);
    tick(1, 8'h00, 0);

    // Alternation 0,7,0,7 with 4-cycle grant spacing.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick(1, 8'h81, 0);
      chk("alt_id", 32'(bus.gnt_id), (i % 2) ? 32'd7 : 32'd0);
      tick(1, 8'h81, 0);
      tick(1, 8'h81, 1);
      tick(1, 8'h81, 0);
    end

    // Full sweep with wrap from 7 back to 0.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      tick(1, 8'hFF, 0);
      chk("wrap_id", 32'(bus.gnt_id), 32'(i % 8));
      tick(1, 8'hFF, 1);
      tick(1, 8'hFF, 0);
    end

    // Hold timeout on requester 2.
    do_reset();
    tick(1, 8'h04, 0);
    held = 1;
    tos = 0;
    for (int i = 0; i < 17; i++) begin
      tick(1, 8'h04, 0);
      if (bus.gnt_valid) held++;
      if (bus.timeout) tos++;
    end
    chk("hold_cycles", 32'(held), 32'd16);
    chk("timeout_cnt", 32'(tos), 32'd1);
    tick(1, 8'h04, 0);
    chk("after_to_id", 32'(bus.gnt_id), 32'd2);
    chk("after_to_v", 32'(bus.gnt_valid), 32'd1);
    tick(1, 8'h04, 1);
    tick(1, 8'h00, 0);

    // Enable gating.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick(0, 8'hFF, 0);
      chk("en0_valid", 32'(bus.gnt_valid), 32'd0);
    end
    tick(1, 8'hFF, 0);
    for (int i = 0; i < 4; i++) begin
      tick(0, 8'hFF, 0);
      chk("en_drop_v", 32'(bus.gnt_valid), 32'd1);
    end
    tick(0, 8'hFF, 1);
    chk("en_done_v", 32'(bus.gnt_valid), 32'd0);
    tick(0, 8'h00, 0);

    // Async reset mid-grant of requester 5.
    do_reset();
    tick(1, 8'h20, 0);
    chk("own5", 32'(bus.gnt_id), 32'd5);
    tick(1, 8'h20, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_gnt", 32'(bus.gnt), 32'h0);
    chk("async_v", 32'(bus.gnt_valid), 32'h0);
    model_reset();
    bus.en = 1'b0;
    bus.req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    compare();
    tick(1, 8'hFF, 0);
    chk("post_rst_id", 32'(bus.gnt_id), 32'd0);
    tick(1, 8'hFF, 1);
    tick(1, 8'h00, 0);

    // Randomized traffic.
    r = 8'($urandom);
    for (int i = 0; i < 3000; i++) begin
      e = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) r = 8'($urandom);
      d = ($urandom_range(0, 9) == 0);
      tick(e, r, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- Round-robin arbiter that shares one 8:3 encoder-style resource among 8 requesters.
- Selects one requester, issues a one-hot grant plus its 3-bit index, and holds the grant until release or timeout.
- After each release, rotates priority to the requester after the one just served.
- Sits in front of the shared datapath; gnt_id drives the datapath select.

Parameters:
- N, 8, number of requesters; fixed at 8 in this release.
- IDW, 3, index width, log2(N).
- MAX_HOLD, 16, maximum cycles a grant may be held before forced release; legal range 2..256.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  arbitration enable; gates new grants only.
- req  in  N  request vector; bit i = requester i.
- done  in  1  release pulse from the current owner.
- gnt  out  N  one-hot grant; all zeros when idle.
- gnt_id  out  IDW  index of the current owner.
- gnt_valid  out  1  high while a grant is held.
- timeout  out  1  one-cycle pulse on forced release.

Behaviour:
- Reset (async assert, sync release):
  - gnt=0, gnt_id=0, gnt_valid=0, timeout=0.
  - State IDLE, priority pointer ptr=0, hold counter hcnt=0.
  - Reset mid-grant drops the grant immediately and returns the pointer to 0.
- All outputs are registered.
- States: IDLE, BUSY, RELEASE.
- IDLE:
  - If en=1 and req!=0, pick the first set req bit scanning ptr, ptr+1, ..., ptr+7 (mod 8).
  - Next edge: gnt=onehot(w), gnt_id=w, gnt_valid=1, hcnt=0, go to BUSY.
  - Grant latency is one cycle from a sampled request.
  - If en=0 or req=0, stay in IDLE; outputs stay at idle values.
- BUSY:
  - hcnt increments every cycle and saturates at MAX_HOLD-1.
  - Release condition: done=1, or req[gnt_id]=0, or hcnt==MAX_HOLD-1.
  - On release: next edge gnt=0, gnt_valid=0, ptr=(gnt_id+1) mod 8, go to RELEASE.
  - gnt_id keeps its last value.
  - timeout=1 for that one cycle only when the release was forced by hcnt and neither done nor req drop occurred the same cycle.
  - en=0 during BUSY has no effect; the current grant completes.
- RELEASE: exactly one bubble cycle with no grant, then IDLE unconditionally. Back-to-back grants are therefore at least 2 cycles apart.
- done while IDLE or RELEASE is ignored.
- Simultaneous done and timeout: treated as a normal release, timeout=0.
- Requests other than the owner's are ignored while BUSY; there is no preemption.
- Pointer wrap: owner 7 releases -> ptr=0.
- Invariant: gnt is zero or exactly one-hot, and gnt[gnt_id]==gnt_valid.

Decomposition:
- Package arb_pkg:
  - N, IDW, MAX_HOLD defaults.
  - State enum (IDLE, BUSY, RELEASE).
  - onehot/index helper function.
- Sub-module rr_prio_enc: combinational rotate-by-ptr priority encoder.
  - Inputs req[N-1:0], ptr[IDW-1:0].
  - Outputs any, idx[IDW-1:0].
- The top level holds the FSM, pointer, hold counter and output registers.

Test Plan:
- Reset then req=8'b0000_0001, en=1 -> next edge gnt=0000_0001, gnt_id=0, gnt_valid=1. Pulse done -> gnt=0 next edge, ptr=1, one bubble cycle.
- req=8'b1000_0001 held, done pulsed 2 cycles after each grant -> grants alternate id 0, 7, 0, 7; grant edges are 4 cycles apart (2-cycle hold + release edge + bubble).
- Owner id 7 releases with req=8'b1111_1111 -> next grant id 0 (wrap); the sequence 0..7 repeats in order.
- req=8'b0000_0100 held, done never asserted, MAX_HOLD=16 -> gnt held 16 cycles, timeout=1 for exactly one cycle, then next grant id 2 after the bubble.
- en=0 with req=8'hFF -> no grant. en dropped during BUSY -> grant persists until done.
- rst_n pulsed low mid-BUSY (owner id 5) -> gnt=0 asynchronously. After reset, req=8'hFF -> grant id 0 (pointer reset).
